// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RV32I pipeline.
//   XLEN             : architectural register / address width
//   NOP_INSTR        : bubble instruction (addi x0,x0,0)
//   RESET_PC_DEFAULT : fetch PC after reset unless overridden
//   fetch_state_e    : fetch-stage memory handshake states
package riscv_pipe_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // REQ  : free to issue a request
  // WAIT : request granted, response still owed
  // DROP : granted request was squashed by a redirect, swallow its response
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding buffer for a fetched {instr, pc, pc+4} triple that
// arrives while Decode is stalled.
//   clk, reset   : clock, synchronous active-low reset
//   clr          : drop the held entry (highest priority)
//   wr_en        : capture wr_* as the held entry
//   rd_en        : entry consumed by the IF/ID register
//   wr_instr/wr_pc/wr_pcplus4 : entry to capture
//   valid        : an entry is held
//   instr/pc/pcplus4          : the held entry
module if_skid_buf
  import riscv_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [XLEN-1:0] wr_instr,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_pcplus4,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;

  // Clear beats write beats read. The payload only moves on a write; the
  // valid flag alone decides whether the held payload means anything.
  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    if (wr_en) begin
      instr_d   = wr_instr;
      pc_d      = wr_pc;
      pcplus4_d = wr_pcplus4;
    end
    if (clr) begin
      valid_d = 1'b0;
    end else if (wr_en) begin
      valid_d = 1'b1;
    end else if (rd_en) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers; reset leaves it empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      pcplus4_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
    end
  end

  assign valid   = valid_q;
  assign instr   = instr_q;
  assign pc      = pc_q;
  assign pcplus4 = pcplus4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage and IF/ID register. Holds PCF, issues single-outstanding
// requests over a req/gnt/rvalid instruction-memory handshake, applies
// Execute redirects and presents the fetched instruction to Decode.
//   clk, reset                  : clock, synchronous active-low reset
//   StallF, StallD, FlushD      : hazard-unit controls
//   PCSrcE, PCTargetE           : taken branch/jump and its target
//   imem_req/imem_addr          : request to instruction memory
//   imem_gnt/imem_rvalid/imem_rdata : grant and response from memory
//   PCF                         : current fetch PC
//   InstrD/PCD/PCPlus4D/ValidD  : IF/ID register contents
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pipe_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = riscv_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  import riscv_pipe_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] instr_d_q, instr_d_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic [XLEN-1:0] pcplus4_d_q, pcplus4_d_d;
  logic            valid_d_q, valid_d_d;

  logic            buf_valid;
  logic [XLEN-1:0] buf_instr, buf_pc, buf_pcplus4;
  logic            buf_wr, buf_rd;
  logic            resp_fire, direct_load;
  logic [XLEN-1:0] req_pcplus4;

  // A held buffer entry blocks new requests, so only one response can ever
  // be waiting for Decode.
  assign imem_req    = (state_q == REQ) & ~StallF & ~buf_valid & ~PCSrcE;
  assign imem_addr   = pcf_q;
  assign req_pcplus4 = req_pc_q + 32'd4;

  // A response is kept only when it belongs to a live request and no
  // redirect is discarding it in the same cycle.
  assign resp_fire   = (state_q == WAIT) & imem_rvalid & ~PCSrcE;
  assign direct_load = resp_fire & ~StallD & ~FlushD & ~buf_valid;
  assign buf_wr      = resp_fire & StallD & ~FlushD;
  assign buf_rd      = buf_valid & ~StallD & ~FlushD;

  if_skid_buf u_skid_buf (
    .clk        (clk),
    .reset      (reset),
    .clr        (FlushD),
    .wr_en      (buf_wr),
    .rd_en      (buf_rd),
    .wr_instr   (imem_rdata),
    .wr_pc      (req_pc_q),
    .wr_pcplus4 (req_pcplus4),
    .valid      (buf_valid),
    .instr      (buf_instr),
    .pc         (buf_pc),
    .pcplus4    (buf_pcplus4)
  );

  // Fetch FSM and PC. A redirect always overrides the +4 step; a redirect
  // while a response is still owed moves to DROP so the stale data is eaten.
  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    req_pc_d = req_pc_q;
    case (state_q)
      REQ: begin
        if (imem_req && imem_gnt) begin
          req_pc_d = pcf_q;
          pcf_d    = pcf_q + 32'd4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end else if (PCSrcE) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
    if (PCSrcE) begin
      pcf_d = PCTargetE;
    end
  end

  // IF/ID register: flush, then stall, then buffered entry, then a direct
  // response, else a bubble. Bubbles and flushes keep the old PCD/PCPlus4D.
  always_comb begin
    instr_d_d   = instr_d_q;
    pc_d_d      = pc_d_q;
    pcplus4_d_d = pcplus4_d_q;
    valid_d_d   = valid_d_q;
    if (FlushD) begin
      instr_d_d = NOP_INSTR;
      valid_d_d = 1'b0;
    end else if (StallD) begin
      valid_d_d = valid_d_q;
    end else if (buf_valid) begin
      instr_d_d   = buf_instr;
      pc_d_d      = buf_pc;
      pcplus4_d_d = buf_pcplus4;
      valid_d_d   = 1'b1;
    end else if (direct_load) begin
      instr_d_d   = imem_rdata;
      pc_d_d      = req_pc_q;
      pcplus4_d_d = req_pcplus4;
      valid_d_d   = 1'b1;
    end else begin
      instr_d_d = NOP_INSTR;
      valid_d_d = 1'b0;
    end
  end

  // All stage state; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= REQ;
      pcf_q       <= RESET_PC;
      req_pc_q    <= '0;
      instr_d_q   <= NOP_INSTR;
      pc_d_q      <= '0;
      pcplus4_d_q <= '0;
      valid_d_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      req_pc_q    <= req_pc_d;
      instr_d_q   <= instr_d_d;
      pc_d_q      <= pc_d_d;
      pcplus4_d_q <= pcplus4_d_d;
      valid_d_q   <= valid_d_d;
    end
  end

  assign PCF      = pcf_q;
  assign InstrD   = instr_d_q;
  assign PCD      = pc_d_q;
  assign PCPlus4D = pcplus4_d_q;
  assign ValidD   = valid_d_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage. A memory model grants requests
// and returns a fixed address-derived word; every grant pushes the expected
// Decode triple for the program-order PC kept by the bench. A monitor pops
// and compares whenever Decode is presented a new valid instruction.
module tb_if_fetch_stage;
  import riscv_pipe_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } fetch_item_t;

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int          tests_run = 0;
  int          tests_failed = 0;
  fetch_item_t exp_q[$];
  logic [31:0] model_pc;
  int          gnt_pct, rv_min, rv_max, grant_count;
  logic        pending;
  int          rv_cnt;
  logic [31:0] resp_data;
  logic        last_reset, last_stall, last_flush;
  logic        mon_en;
  logic [31:0] rnd_tgt;

  if_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory: an arbitrary but fixed word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'h1234_5677;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  // Redirects always come with FlushD, as the hazard unit would do; either
  // a redirect or a reset abandons everything still expected.
  task automatic applyStimulus(input logic sf, input logic sd, input logic redir,
                               input logic [31:0] tgt, input logic rst_n);
    StallF    = sf;
    StallD    = sd;
    PCSrcE    = redir;
    FlushD    = redir;
    PCTargetE = redir ? tgt : $urandom;
    reset     = rst_n;
    if (!rst_n) begin
      exp_q.delete();
      model_pc = RESET_PC_DEFAULT;
    end else if (redir) begin
      exp_q.delete();
      model_pc = tgt;
    end
  endtask

  task automatic waitGrant(input string what);
    int gc0 = grant_count;
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      if (grant_count != gc0) seen = 1'b1;
    end
    checkOutput({what, "_grant_seen"}, 32'(seen), 32'd1);
  endtask

  // Memory model: random grants, response 1..N cycles after the grant.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      pending     = 1'b0;
    end else begin
      if (pending && rv_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = resp_data;
        pending     = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pending) rv_cnt--;
      end
      imem_gnt = ($urandom_range(99) < gnt_pct);
      #1;
      if (imem_req && imem_gnt) begin
        checkOutput("imem_addr", imem_addr, model_pc);
        resp_data = mem_word(imem_addr);
        exp_q.push_back('{instr: mem_word(model_pc), pc: model_pc, pcp4: model_pc + 32'd4});
        model_pc  = model_pc + 32'd4;
        pending   = 1'b1;
        rv_cnt    = $urandom_range(rv_max - 1, rv_min - 1);
        grant_count++;
      end
    end
  end

  always @(posedge clk) begin
    last_reset <= reset;
    last_stall <= StallD;
    last_flush <= FlushD;
  end

  // Monitor: a new IF/ID value appears after any edge without StallD.
  always @(negedge clk) begin : monitor
    fetch_item_t item;
    if (mon_en) begin
      if (!last_reset || last_flush) begin
        checkOutput("bubble_ValidD", 32'(ValidD), 32'd0);
        checkOutput("bubble_InstrD", InstrD, NOP_INSTR);
      end else if (!last_stall && ValidD) begin
        checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          item = exp_q.pop_front();
          checkOutput("InstrD", InstrD, item.instr);
          checkOutput("PCD", PCD, item.pc);
          checkOutput("PCPlus4D", PCPlus4D, item.pcp4);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mon_en = 1'b0; pending = 1'b0; rv_cnt = 0; grant_count = 0;
    gnt_pct = 100; rv_min = 1; rv_max = 1; model_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; resp_data = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset state
    repeat (3) cycle();
    checkOutput("rst_PCF", PCF, 32'h0);
    checkOutput("rst_ValidD", 32'(ValidD), 32'd0);
    checkOutput("rst_InstrD", InstrD, NOP_INSTR);
    checkOutput("rst_PCD", PCD, 32'h0);
    checkOutput("rst_PCPlus4D", PCPlus4D, 32'h0);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd1);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    mon_en = 1'b1;

    // Zero-wait memory: 0,4,8,... checked by the scoreboard
    repeat (8) cycle();

    // Redirect while WAIT, response two cycles after grant is discarded
    rv_min = 2; rv_max = 2;
    waitGrant("redir");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
    cycle();
    checkOutput("redir_PCF", PCF, 32'h0000_0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    rv_min = 1; rv_max = 1;
    repeat (8) cycle();

    // StallD while a response lands: buffered, requests blocked, then resume
    waitGrant("stall");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) cycle();
    checkOutput("stall_imem_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (8) cycle();

    // Flush with a buffered entry (flush wins over stall)
    waitGrant("flush");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (2) cycle();
    checkOutput("flush_pre_imem_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    cycle();
    checkOutput("flush_InstrD", InstrD, NOP_INSTR);
    checkOutput("flush_ValidD", 32'(ValidD), 32'd0);
    checkOutput("flush_PCF", PCF, 32'h0000_0200);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (8) cycle();

    // Grant withheld four cycles: request and address stable, PCF frozen
    gnt_pct = 0;
    repeat (4) cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      checkOutput("gntwait_imem_req", 32'(imem_req), 32'd1);
      checkOutput("gntwait_imem_addr", imem_addr, model_pc);
      checkOutput("gntwait_PCF", PCF, model_pc);
    end
    gnt_pct = 100;
    cycle();
    checkOutput("gnt_PCF_step", PCF, model_pc);
    repeat (6) cycle();

    // Reset while WAIT
    rv_min = 3; rv_max = 3;
    waitGrant("rstwait");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    checkOutput("rstwait_PCF", PCF, RESET_PC_DEFAULT);
    checkOutput("rstwait_ValidD", 32'(ValidD), 32'd0);
    checkOutput("rstwait_imem_req", 32'(imem_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    rv_min = 1; rv_max = 1;
    repeat (6) cycle();

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    waitGrant("wrap");
    checkOutput("wrap_PCF", PCF, 32'h0);
    repeat (6) cycle();

    // Randomized traffic
    rv_min = 1; rv_max = 4;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) gnt_pct = $urandom_range(100, 30);
      cycle();
      rnd_tgt = $urandom & 32'hFFFF_FFFC;
      applyStimulus($urandom_range(99) < 20, $urandom_range(99) < 25,
                    $urandom_range(99) < 4, rnd_tgt, !($urandom_range(999) < 3));
    end

    // Drain: stop issuing and make sure every expected item was delivered
    cycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (20) cycle();
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Fetch stage plus IF/ID pipeline register for the 5-stage RV32I pipeline. Holds PCF and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. Applies branch/jump redirects from Execute and presents InstrD/PCD/PCPlus4D/ValidD to Decode, which feeds the ID/EX register. A one-entry skid buffer absorbs a response that arrives while Decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PCF value after reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on InstrD when not valid.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low; 0 at a rising edge resets
StallF  in  1  hazard unit: do not issue a new fetch
StallD  in  1  hazard unit: hold IF/ID register
FlushD  in  1  hazard unit: squash IF/ID contents and skid buffer
PCSrcE  in  1  Execute: taken branch/jump
PCTargetE  in  32  Execute: redirect target
imem_req  out  1  request valid
imem_addr  out  32  request address (= PCF)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid (at least 1 cycle after gnt)
imem_rdata  in  32  response instruction
PCF  out  32  current fetch PC
InstrD  out  32  IF/ID instruction
PCD  out  32  IF/ID PC
PCPlus4D  out  32  IF/ID PC+4
ValidD  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (reset==0 at posedge): PCF=RESET_PC; state=REQ; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0; buffer empty; req_pc=0. Reset mid-transaction drops any outstanding response. The first rvalid after reset is ignored only if it belongs to a pre-reset request; the memory is required to be reset together with this block.
- States: REQ (may issue), WAIT (request granted, awaiting rvalid), DROP (granted request squashed, awaiting rvalid to discard).
- imem_req = (state==REQ) & !StallF & !buf_valid & !PCSrcE. imem_addr = PCF always.
- REQ, imem_req & imem_gnt: req_pc<=PCF; PCF<=PCF+4 (mod 2^32, wraps); go to WAIT. Request held stable until gnt.
- Any state, PCSrcE=1: PCF<=PCTargetE, with priority over the +4 update. In WAIT: go to DROP if !imem_rvalid, else discard the data and go to REQ. In DROP: remain there until rvalid.
- WAIT, imem_rvalid & !PCSrcE: go to REQ. Deliver {imem_rdata, req_pc, req_pc+4}:
  - If !StallD & !FlushD & !buf_valid: load directly into IF/ID with ValidD=1 (fetch-to-decode latency = rvalid cycle + 1 edge).
  - Otherwise, if StallD: write to the buffer.
- DROP, imem_rvalid: discard; go to REQ.
- IF/ID update priority:
  1. FlushD: InstrD=NOP_INSTR, ValidD=0, buffer cleared. PCD/PCPlus4D hold.
  2. StallD: all hold.
  3. buf_valid: load from buffer, clear buffer.
  4. Direct response as above.
  5. Otherwise: bubble (NOP_INSTR, ValidD=0, PCD/PCPlus4D hold).
- Only one outstanding request, so at most one buffered entry. The buffer cannot overflow because imem_req is gated by buf_valid.
- FlushD with StallD: the flush wins.

Decomposition:
- Shared package riscv_pipe_pkg: NOP_INSTR, RESET_PC default, fetch state enum {REQ, WAIT, DROP}, XLEN=32.
- One sub-module: if_skid_buf, a one-entry {instr, pc, pcplus4} buffer with write/read/clear and a valid flag.
- The FSM, PCF and IF/ID register stay in the top module.

Test Plan:
- Reset, zero-wait memory (gnt=1, rvalid next cycle): imem_addr sequence 0,4,8; InstrD follows with ValidD=1, PCD 0,4,8, PCPlus4D 4,8,12.
- PCSrcE=1 with PCTargetE=0x100 while in WAIT, rvalid two cycles later: that response is discarded, PCF=0x100, next imem_addr=0x100, ValidD stays 0 until the 0x100 instruction arrives.
- StallD=1 for 3 cycles as a response for PC 0x8 arrives: buffer fills, imem_req=0, InstrD/PCD unchanged. On release, PCD=0x8 loads next edge, then fetch resumes at 0xC.
- FlushD=1 with a buffered entry present: InstrD=0x00000013, ValidD=0, buffer empty, next delivered instruction is from the redirect target.
- gnt delayed 4 cycles: imem_req and imem_addr stable throughout, PCF increments only on the gnt cycle.
- reset=0 while in WAIT: next cycle state=REQ, PCF=RESET_PC, ValidD=0. PCF=0xFFFFFFFC granted: PCF wraps to 0x0.
